// File: rtl/sccb_slave.sv
// SCCB/I2C target: decodes 3-phase writes and 2-phase reads, drives SDA low only,
// and exposes a strobe-based register-file interface.
module sccb_slave #(
    parameter logic [6:0] DEV_ADDR = 7'h30,
    parameter bit         AUTO_INC = 1'b0
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_we,
    output logic       reg_re,
    input  logic [7:0] reg_rdata,
    output logic       busy
);
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned CNT_W  = 4;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(7);
    localparam logic [CNT_W-1:0] ACK_SLOT = CNT_W'(8);

    typedef enum logic [3:0] {
        IDLE, DEV, DEV_ACK, REG, REG_ACK, WR, WR_ACK, RD, RD_ACK, IGNORE, WAIT_STOP
    } state_t;

    state_t              state, state_nxt;
    logic                scl_s1, scl_s2, scl_d, sda_s1, sda_s2, sda_d;
    logic                scl_rise, scl_fall, start_cond, stop_cond;
    logic [CNT_W-1:0]    bit_cnt, bit_cnt_nxt;
    logic [BYTE_W-1:0]   shift, shift_nxt, byte_in;
    logic [1:0]          load_pipe, load_nxt;
    logic                sda_oe_nxt, reg_we_nxt, reg_re_nxt, busy_nxt;
    logic [BYTE_W-1:0]   reg_addr_nxt, reg_wdata_nxt;

    // Two-flop synchronisers plus one delay stage for edge detection; idle bus reads high
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            {scl_s1, scl_s2, scl_d} <= 3'b111;
            {sda_s1, sda_s2, sda_d} <= 3'b111;
        end else begin
            {scl_s1, scl_s2, scl_d} <= {scl_in, scl_s1, scl_s2};
            {sda_s1, sda_s2, sda_d} <= {sda_in, sda_s1, sda_s2};
        end
    end

    // Bus events; conditions need SCL stable high so simultaneous SCL/SDA changes count as data
    assign scl_rise   = scl_s2 & ~scl_d;
    assign scl_fall   = ~scl_s2 & scl_d;
    assign start_cond = scl_s2 & scl_d & sda_d & ~sda_s2;
    assign stop_cond  = scl_s2 & scl_d & ~sda_d & sda_s2;
    assign byte_in    = {shift[BYTE_W-2:0], sda_s2};

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // Next-state and next-output logic
    always_comb begin
        state_nxt     = state;
        bit_cnt_nxt   = bit_cnt;
        shift_nxt     = shift;
        load_nxt      = {load_pipe[0], 1'b0};
        sda_oe_nxt    = sda_oe;
        reg_addr_nxt  = reg_addr;
        reg_wdata_nxt = reg_wdata;
        reg_we_nxt    = 1'b0;
        reg_re_nxt    = 1'b0;
        busy_nxt      = busy;

        if (AUTO_INC && reg_we) reg_addr_nxt = reg_addr + 8'd1;

        if (stop_cond) begin
            state_nxt   = IDLE;
            sda_oe_nxt  = 1'b0;
            busy_nxt    = 1'b0;
            bit_cnt_nxt = '0;
            load_nxt    = '0;
        end else if (start_cond) begin
            state_nxt   = DEV;
            sda_oe_nxt  = 1'b0;
            bit_cnt_nxt = '0;
            load_nxt    = '0;
        end else begin
            case (state)
                DEV, REG, WR: begin
                    if (scl_rise && bit_cnt < ACK_SLOT) begin
                        shift_nxt   = byte_in;
                        bit_cnt_nxt = bit_cnt + CNT_W'(1);
                        if (bit_cnt == LAST_BIT && state == REG) reg_addr_nxt = byte_in;
                        if (bit_cnt == LAST_BIT && state == WR) begin
                            reg_wdata_nxt = byte_in;
                            reg_we_nxt    = 1'b1;
                        end
                    end else if (scl_fall && bit_cnt == ACK_SLOT) begin
                        sda_oe_nxt = 1'b1;
                        if (state == REG)     state_nxt = REG_ACK;
                        else if (state == WR) state_nxt = WR_ACK;
                        else if (shift[7:1] == DEV_ADDR) begin
                            state_nxt = DEV_ACK;
                            busy_nxt  = 1'b1;
                        end else begin
                            state_nxt  = IGNORE;
                            sda_oe_nxt = 1'b0;
                            busy_nxt   = 1'b0;
                        end
                    end
                end
                DEV_ACK, REG_ACK, WR_ACK: begin
                    // Entered with bit_cnt at the ACK slot; its rising edge wraps the counter
                    if (scl_rise) bit_cnt_nxt = '0;
                    else if (scl_fall && bit_cnt == '0) begin
                        sda_oe_nxt = 1'b0;
                        if (state != DEV_ACK || !shift[0]) begin
                            state_nxt = (state == DEV_ACK) ? REG : WR;
                        end else begin
                            state_nxt  = RD;
                            reg_re_nxt = 1'b1;
                            load_nxt   = 2'b01;
                        end
                    end
                end
                RD: begin
                    if (load_pipe[1]) begin
                        shift_nxt   = reg_rdata;
                        sda_oe_nxt  = ~reg_rdata[7];
                        bit_cnt_nxt = '0;
                    end else if (scl_rise && bit_cnt < ACK_SLOT) begin
                        bit_cnt_nxt = bit_cnt + CNT_W'(1);
                    end else if (scl_fall) begin
                        if (bit_cnt == ACK_SLOT) begin
                            sda_oe_nxt = 1'b0;
                            state_nxt  = RD_ACK;
                        end else begin
                            shift_nxt  = {shift[BYTE_W-2:0], 1'b0};
                            sda_oe_nxt = ~shift[6];
                        end
                    end
                end
                RD_ACK: begin
                    // shift[0] holds the master's ACK (0) / NACK (1)
                    if (scl_rise) begin
                        shift_nxt[0] = sda_s2;
                        bit_cnt_nxt  = '0;
                    end else if (scl_fall && bit_cnt == '0) begin
                        if (shift[0]) state_nxt = WAIT_STOP;
                        else begin
                            state_nxt  = RD;
                            reg_re_nxt = 1'b1;
                            load_nxt   = 2'b01;
                            if (AUTO_INC) reg_addr_nxt = reg_addr + 8'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Registered datapath and outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bit_cnt   <= '0;
            shift     <= '0;
            load_pipe <= '0;
            sda_oe    <= 1'b0;
            reg_addr  <= '0;
            reg_wdata <= '0;
            reg_we    <= 1'b0;
            reg_re    <= 1'b0;
            busy      <= 1'b0;
        end else begin
            bit_cnt   <= bit_cnt_nxt;
            shift     <= shift_nxt;
            load_pipe <= load_nxt;
            sda_oe    <= sda_oe_nxt;
            reg_addr  <= reg_addr_nxt;
            reg_wdata <= reg_wdata_nxt;
            reg_we    <= reg_we_nxt;
            reg_re    <= reg_re_nxt;
            busy      <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_sccb_slave.sv
// Bench for sccb_slave: bit-banged SCCB master on a shared open-drain bus with two targets
// (0x30 fixed address, 0x31 auto-increment).
module tb_sccb_slave;
    localparam int unsigned Q = 8;  // clk cycles per quarter SCL period

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       scl = 1'b1;
    logic       sda_m = 1'b1;
    logic       sda_bus;
    logic       oe0, oe1, we0, we1, re0, re1, busy0, busy1;
    logic [7:0] addr0, addr1, wdata0, wdata1;
    logic [7:0] rdata0 = 8'h26;
    logic [7:0] rdata1 = 8'h00;

    int errors = 0;
    int checks = 0;
    int we0_cnt = 0, re0_cnt = 0, we1_cnt = 0, re1_cnt = 0, both_cnt = 0;
    int oe_seen = 0, busy_seen = 0;
    logic [7:0] we0_addr, we0_data;
    logic [7:0] q1_addr[$];
    logic [7:0] q1_data[$];

    always #5 clk = ~clk;

    assign sda_bus = sda_m & ~oe0 & ~oe1;

    sccb_slave #(.DEV_ADDR(7'h30), .AUTO_INC(1'b0)) u_fix (
        .clk(clk), .reset_n(reset_n), .scl_in(scl), .sda_in(sda_bus), .sda_oe(oe0),
        .reg_addr(addr0), .reg_wdata(wdata0), .reg_we(we0), .reg_re(re0),
        .reg_rdata(rdata0), .busy(busy0));

    sccb_slave #(.DEV_ADDR(7'h31), .AUTO_INC(1'b1)) u_inc (
        .clk(clk), .reset_n(reset_n), .scl_in(scl), .sda_in(sda_bus), .sda_oe(oe1),
        .reg_addr(addr1), .reg_wdata(wdata1), .reg_we(we1), .reg_re(re1),
        .reg_rdata(rdata1), .busy(busy1));

    // Strobe monitor, sampled away from the active edge
    always @(negedge clk) begin
        if (we0) begin we0_cnt++; we0_addr = addr0; we0_data = wdata0; end
        if (re0) re0_cnt++;
        if (we1) begin we1_cnt++; q1_addr.push_back(addr1); q1_data.push_back(wdata1); end
        if (re1) re1_cnt++;
        if ((we0 && re0) || (we1 && re1)) both_cnt++;
        if (oe0 || oe1) oe_seen++;
        if (busy0 || busy1) busy_seen++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_q();
        repeat (Q) @(negedge clk);
    endtask

    task automatic clr_mon();
        we0_cnt = 0; re0_cnt = 0; we1_cnt = 0; re1_cnt = 0;
        oe_seen = 0; busy_seen = 0;
        q1_addr.delete(); q1_data.delete();
    endtask

    task automatic bus_start();
        sda_m = 1'b1; wait_q(); scl = 1'b1; wait_q();
        sda_m = 1'b0; wait_q(); scl = 1'b0; wait_q();
    endtask

    task automatic bus_stop();
        sda_m = 1'b0; wait_q(); scl = 1'b1; wait_q();
        sda_m = 1'b1; wait_q();
    endtask

    task automatic write_bit(input logic b);
        sda_m = b; wait_q(); scl = 1'b1; wait_q(); wait_q(); scl = 1'b0; wait_q();
    endtask

    task automatic read_bit(output logic b);
        sda_m = 1'b1; wait_q(); scl = 1'b1; wait_q(); b = sda_bus; wait_q(); scl = 1'b0; wait_q();
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) write_bit(d[i]);
        read_bit(ack);
    endtask

    task automatic read_byte(output logic [7:0] d, input logic nack);
        logic b;
        for (int i = 7; i >= 0; i--) begin read_bit(b); d[i] = b; end
        write_bit(nack);
    endtask

    initial begin
        logic       a0, a1, a2, a3;
        logic [7:0] rd;

        // Reset state
        repeat (5) @(negedge clk);
        check_eq("rst_sda_oe", 32'(oe0), 32'h0);
        check_eq("rst_reg_addr", 32'(addr0), 32'h0);
        check_eq("rst_reg_wdata", 32'(wdata0), 32'h0);
        check_eq("rst_reg_we", 32'(we0), 32'h0);
        check_eq("rst_reg_re", 32'(re0), 32'h0);
        check_eq("rst_busy", 32'(busy0), 32'h0);
        reset_n = 1'b1;
        wait_q();

        // 1: plain 3-phase write
        clr_mon();
        bus_start();
        write_byte(8'h60, a0); write_byte(8'hFF, a1); write_byte(8'h01, a2);
        check_eq("t1_ack_dev", 32'(a0), 32'h0);
        check_eq("t1_ack_reg", 32'(a1), 32'h0);
        check_eq("t1_ack_dat", 32'(a2), 32'h0);
        check_eq("t1_busy_before_stop", 32'(busy0), 32'h1);
        bus_stop(); wait_q();
        check_eq("t1_we_count", 32'(we0_cnt), 32'd1);
        check_eq("t1_we_addr", 32'(we0_addr), 32'hFF);
        check_eq("t1_we_data", 32'(we0_data), 32'h01);
        check_eq("t1_busy_after_stop", 32'(busy0), 32'h0);

        // 2: address mismatch is ignored entirely
        clr_mon();
        bus_start();
        write_byte(8'h42, a0); write_byte(8'h12, a1); write_byte(8'h34, a2);
        bus_stop(); wait_q();
        check_eq("t2_no_ack", 32'({a0, a1, a2}), 32'h7);
        check_eq("t2_oe_seen", 32'(oe_seen), 32'd0);
        check_eq("t2_we_re", 32'(we0_cnt + re0_cnt + we1_cnt + re1_cnt), 32'd0);
        check_eq("t2_busy_seen", 32'(busy_seen), 32'd0);

        // 3: set address then 2-phase read with master NACK
        clr_mon();
        bus_start(); write_byte(8'h60, a0); write_byte(8'h0A, a1); bus_stop(); wait_q();
        bus_start(); write_byte(8'h61, a2);
        read_byte(rd, 1'b1);
        check_eq("t3_ack", 32'({a0, a1, a2}), 32'h0);
        check_eq("t3_rdata", 32'(rd), 32'h26);
        check_eq("t3_re_count", 32'(re0_cnt), 32'd1);
        check_eq("t3_reg_addr", 32'(addr0), 32'h0A);
        check_eq("t3_busy_wait_stop", 32'(busy0), 32'h1);
        read_byte(rd, 1'b1);
        check_eq("t3_released_after_nack", 32'(rd), 32'hFF);
        check_eq("t3_re_count_after", 32'(re0_cnt), 32'd1);
        bus_stop(); wait_q();
        check_eq("t3_busy_after_stop", 32'(busy0), 32'h0);
        check_eq("t3_no_we", 32'(we0_cnt), 32'd0);

        // 4: repeated START mid data byte discards the partial byte
        clr_mon();
        bus_start(); write_byte(8'h60, a0); write_byte(8'h55, a1);
        write_bit(1'b1); write_bit(1'b0); write_bit(1'b1); write_bit(1'b1);
        bus_start();
        write_byte(8'h60, a2); write_byte(8'h12, a3); write_byte(8'h80, a0);
        bus_stop(); wait_q();
        check_eq("t4_we_count", 32'(we0_cnt), 32'd1);
        check_eq("t4_we_addr", 32'(we0_addr), 32'h12);
        check_eq("t4_we_data", 32'(we0_data), 32'h80);

        // 5: auto-increment across the 8'hFF wrap
        clr_mon();
        bus_start();
        write_byte(8'h62, a0); write_byte(8'hFE, a1); write_byte(8'h11, a2);
        write_byte(8'h22, a3); write_byte(8'h33, a0);
        bus_stop(); wait_q();
        check_eq("t5_we_count", 32'(we1_cnt), 32'd3);
        if (q1_addr.size() == 3) begin
            check_eq("t5_addr0", 32'(q1_addr[0]), 32'hFE);
            check_eq("t5_data0", 32'(q1_data[0]), 32'h11);
            check_eq("t5_addr1", 32'(q1_addr[1]), 32'hFF);
            check_eq("t5_data1", 32'(q1_data[1]), 32'h22);
            check_eq("t5_addr2", 32'(q1_addr[2]), 32'h00);
            check_eq("t5_data2", 32'(q1_data[2]), 32'h33);
        end
        check_eq("t5_fixed_quiet", 32'(we0_cnt), 32'd0);

        // 6: asynchronous reset while driving the device ACK
        clr_mon();
        bus_start();
        for (int i = 7; i >= 0; i--) write_bit(1'(8'h60 >> i));
        check_eq("t6_ack_driven", 32'(oe0), 32'h1);
        reset_n = 1'b0;
        #1;
        check_eq("t6_oe_async", 32'(oe0), 32'h0);
        check_eq("t6_busy_async", 32'(busy0), 32'h0);
        check_eq("t6_addr_async", 32'(addr0), 32'h0);
        repeat (4) @(negedge clk);
        reset_n = 1'b1;
        scl = 1'b1; sda_m = 1'b1; wait_q(); wait_q();
        clr_mon();
        bus_start();
        write_byte(8'h60, a0); write_byte(8'h07, a1); write_byte(8'h5A, a2);
        bus_stop(); wait_q();
        check_eq("t6_ack_after", 32'({a0, a1, a2}), 32'h0);
        check_eq("t6_we_count", 32'(we0_cnt), 32'd1);
        check_eq("t6_we_addr", 32'(we0_addr), 32'h07);
        check_eq("t6_we_data", 32'(we0_data), 32'h5A);

        check_eq("we_re_exclusive", 32'(both_cnt), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
